// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: folds E0/F0 prefixes into one registered key event
// with make/break and extended tags, optional typematic-repeat suppression and prefix watchdog.
module ps2_scancode_decoder #(
    parameter int             N               = 8,
    parameter logic [N-1:0]   BREAK_CODE      = 8'hF0,
    parameter logic [N-1:0]   EXT_CODE        = 8'hE0,
    parameter int             SUPPRESS_REPEAT = 1,
    parameter int             TIMEOUT         = 100000,
    parameter int             TW              = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_done_tick,
    input  logic [N-1:0] data_in,
    output logic         key_valid,
    output logic [N-1:0] key_code,
    output logic         key_break,
    output logic         key_extended,
    output logic         err_tick
);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK
    } state_e;

    // Last idle-count value before the watchdog fires; the error strobe then lands
    // TIMEOUT cycles after the prefix byte was strobed in.
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 2);

    state_e         state_q, state_d;
    logic           ext_q, ext_d;
    logic           brk_q, brk_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic           held_valid_q, held_valid_d;
    logic [N-1:0]   held_code_q, held_code_d;
    logic           held_ext_q, held_ext_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   code_q, code_d;
    logic           break_q, break_d;
    logic           extd_q, extd_d;
    logic           err_q, err_d;

    logic           ev_req;
    logic           ev_brk;
    logic           ev_ext;
    logic           held_hit;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        state_d      = state_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        cnt_d        = cnt_q;
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        valid_d      = 1'b0;
        code_d       = code_q;
        break_d      = break_q;
        extd_d       = extd_q;
        err_d        = 1'b0;
        ev_req       = 1'b0;
        ev_brk       = 1'b0;
        ev_ext       = 1'b0;
        held_hit     = 1'b0;

        if (rx_done_tick) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (data_in == EXT_CODE) begin
                        state_d = EXT;
                        ext_d   = 1'b1;
                    end else if (data_in == BREAK_CODE) begin
                        state_d = BRK;
                        brk_d   = 1'b1;
                        ext_d   = 1'b0;
                    end else begin
                        ev_req = 1'b1;
                    end
                end
                EXT: begin
                    if (data_in == BREAK_CODE) begin
                        state_d = BRK;
                        brk_d   = 1'b1;
                    end else if (data_in != EXT_CODE) begin
                        ev_req = 1'b1;
                        ev_ext = 1'b1;
                    end
                end
                BRK: begin
                    if (data_in == EXT_CODE) begin
                        // F0 followed by E0 is out of order: flag it and treat E0 as a fresh prefix.
                        err_d   = 1'b1;
                        state_d = EXT;
                        ext_d   = 1'b1;
                        brk_d   = 1'b0;
                    end else if (data_in != BREAK_CODE) begin
                        ev_req = 1'b1;
                        ev_brk = 1'b1;
                        ev_ext = ext_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end

        if (ev_req) begin
            state_d  = IDLE;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
            held_hit = held_valid_q && (held_code_q == data_in) && (held_ext_q == ev_ext);
            if (SUPPRESS_REPEAT == 0 || ev_brk || !held_hit) begin
                valid_d = 1'b1;
                code_d  = data_in;
                break_d = ev_brk;
                extd_d  = ev_ext;
            end
            if (SUPPRESS_REPEAT != 0) begin
                if (ev_brk && held_hit) begin
                    held_valid_d = 1'b0;
                end else if (!ev_brk && !held_hit) begin
                    held_valid_d = 1'b1;
                    held_code_d  = data_in;
                    held_ext_d   = ev_ext;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            cnt_q        <= '0;
            held_valid_q <= 1'b0;
            held_code_q  <= '0;
            held_ext_q   <= 1'b0;
            valid_q      <= 1'b0;
            code_q       <= '0;
            break_q      <= 1'b0;
            extd_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            cnt_q        <= cnt_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            break_q      <= break_d;
            extd_q       <= extd_d;
            err_q        <= err_d;
        end
    end

    assign key_valid    = valid_q;
    assign key_code     = code_q;
    assign key_break    = break_q;
    assign key_extended = extd_q;
    assign err_tick     = err_q;

endmodule
